seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits. It holds a double-buffered BCD frame, walks the digits at a programmable refresh rate, and drives one 4-bit BCD code plus one active-low anode select per cycle. The BCD code feeds the team's combinational BCD-to-segment decoder. Each digit gets a dead-time blank phase to suppress ghosting, and frame updates are committed only at frame boundaries.

---
 rtl/seg_scan_pkg.sv | 12 +
 rtl/seg_scan_timer.sv | 60 ++++++
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the 7-segment scan controller
package seg_scan_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_e;

endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - per-slot phase counter and digit index with slot/frame strobes
module seg_scan_timer
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   parameter int CNT_W        = $clog2(DIGIT_CYCLES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             park,
   output logic [CNT_W-1:0] phase,
   output logic [IDX_W-1:0] idx,
   output logic             blank_end,
   output logic             slot_end,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   assign phase     = cnt_q;
   assign idx       = idx_q;
   assign blank_end = (cnt_q == BLANK_LAST);
   assign slot_end  = (cnt_q == SLOT_LAST);
   assign frame_end = slot_end && (idx_q == IDX_LAST);

   // Advance the phase; at slot end clear it and step to the next digit, park forces slot 0 cycle 0
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (park) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (slot_end) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter and index registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered BCD scan controller; optional SEG_SCAN_LZB_EN leading-zero blanking
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int CNT_W       = $clog2(DIGIT_CYCLES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [BCD_W*NUM_DIGITS-1:0] wr_data,
   output logic [BCD_W-1:0]            bcd,
   output logic [NUM_DIGITS-1:0]       an,
   output logic [IDX_W-1:0]            digit_idx,
   output logic                        frame_done
);

   localparam int FW = BCD_W * NUM_DIGITS;
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DIGIT_CYCLES - 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   state_e                  state_q, state_d;
   logic [FW-1:0]           disp_q, disp_d;
   logic [FW-1:0]           pend_q, pend_d;
   logic                    wr_ready_q, wr_ready_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic                    frame_done_q, frame_done_d;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [BCD_W-1:0]        nibble;

   logic [CNT_W-1:0]        phase;
   logic [IDX_W-1:0]        idx;
   logic                    blank_end;
   logic                    slot_end;
   logic                    frame_end;

   seg_scan_timer #(
      .NUM_DIGITS   (NUM_DIGITS),
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES),
      .IDX_W        (IDX_W),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .park      (!en),
      .phase     (phase),
      .idx       (idx),
      .blank_end (blank_end),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   assign wr_ready   = wr_ready_q;
   assign an         = an_q;
   assign bcd        = bcd_q;
   assign digit_idx  = idx;
   assign frame_done = frame_done_q;

`ifdef SEG_SCAN_LZB_EN
   logic lead;
   // Mark digits whose nibble and all more-significant nibbles are zero; digit 0 always shows
   always_comb begin
      lz_mask = '0;
      lead    = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lead       = lead && (disp_q[i*BCD_W +: BCD_W] == '0);
         lz_mask[i] = lead;
      end
   end
`else
   assign lz_mask = '0;
`endif

   assign nibble = disp_q[idx*BCD_W +: BCD_W];

   // Next state, frame handshake/commit, and output values for the cycle after the edge
   always_comb begin
      state_d      = state_q;
      disp_d       = disp_q;
      pend_d       = pend_q;
      wr_ready_d   = wr_ready_q;
      an_d         = '1;
      bcd_d        = BCD_BLANK;
      frame_done_d = 1'b0;

      if (!en) begin
         state_d = S_BLANK;
      end else begin
         case (state_q)
            S_BLANK: if (blank_end) state_d = S_DRIVE;
            S_DRIVE: if (slot_end)  state_d = S_BLANK;
            default: state_d = S_BLANK;
         endcase
      end

      // Drive is entered and held only while the digit index is stable
      if (state_d == S_DRIVE && !lz_mask[idx]) begin
         an_d[idx] = 1'b0;
         bcd_d     = nibble;
      end

      frame_done_d = en && (idx == IDX_LAST) && (phase == PRE_LAST);

      // A commit needs a pending frame, so it can never collide with an accept
      if (!wr_ready_q && (!en || frame_end)) begin
         disp_d     = pend_q;
         wr_ready_d = 1'b1;
      end else if (wr_ready_q && wr_valid) begin
         pend_d     = wr_data;
         wr_ready_d = 1'b0;
      end
   end

   // State, frame buffers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_BLANK;
         disp_q       <= {NUM_DIGITS{BCD_BLANK}};
         pend_q       <= '0;
         wr_ready_q   <= 1'b1;
         an_q         <= '1;
         bcd_q        <= BCD_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         wr_ready_q   <= wr_ready_d;
         an_q         <= an_d;
         bcd_q        <= bcd_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized bench for seg_scan_ctrl against a frame-position model
module tb_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int DC = 8;
   localparam int BC = 2;
   localparam int FRAME = ND * DC;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_data;
   logic [3:0]  bcd;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   int          m_t;
   logic [15:0] m_disp;
   logic [15:0] m_pend;
   bit          m_pend_v;

   seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .bcd        (bcd),
      .an         (an),
      .digit_idx  (digit_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Model step for one clock edge using the inputs present at that edge
   task automatic model_edge();
      bit accept;
      bit commit;
      if (rst) begin
         m_t      = 0;
         m_disp   = 16'hFFFF;
         m_pend_v = 0;
      end else begin
         accept = wr_valid && !m_pend_v;
         commit = !en || ((m_t + 1) % FRAME == 0);
         m_t    = en ? (m_t + 1) % FRAME : 0;
         if (commit && m_pend_v) begin
            m_disp   = m_pend;
            m_pend_v = 0;
         end
         if (accept) begin
            m_pend   = wr_data;
            m_pend_v = 1;
         end
      end
   endtask

   // Compare every output against what the frame position implies
   task automatic check_outputs();
      int   slot;
      int   ph;
      bit   drive;
      logic [3:0] exp_an;
      logic [3:0] exp_bcd;
      slot  = m_t / DC;
      ph    = m_t % DC;
      drive = (ph >= BC);
`ifdef SEG_SCAN_LZB_EN
      if (slot > 0 && (m_disp >> (4 * slot)) == 16'h0) drive = 0;
`endif
      exp_an  = 4'hF;
      exp_bcd = 4'hF;
      if (drive) begin
         exp_an[slot] = 1'b0;
         exp_bcd      = 4'((m_disp >> (4 * slot)) & 16'hF);
      end
      chk("an", 32'(an), 32'(exp_an));
      chk("bcd", 32'(bcd), 32'(exp_bcd));
      chk("digit_idx", 32'(digit_idx), 32'(slot));
      chk("frame_done", 32'(frame_done), 32'(slot == ND - 1 && ph == DC - 1));
      chk("wr_ready", 32'(wr_ready), 32'(!m_pend_v));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      logic [15:0] mask;
      rst      = 1'b1;
      en       = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      m_t      = 0;
      m_disp   = 16'hFFFF;
      m_pend   = '0;
      m_pend_v = 0;
      @(negedge clk);
      step();
      step();

      // Directed: blank scan with no frame, then 1234 plus an ignored AAAA
      rst = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < FRAME + 3; i++) step();
      wr_valid = 1'b1;
      wr_data  = 16'h1234;
      step();
      wr_data  = 16'hAAAA;
      step();
      wr_valid = 1'b0;
      for (int i = 0; i < 2 * FRAME + 20; i++) step();
      en = 1'b0;
      for (int i = 0; i < 3; i++) step();
      en = 1'b1;
      for (int i = 0; i < FRAME; i++) step();

      // Randomized traffic with occasional park and reset
      for (int i = 0; i < 4000; i++) begin
         rst      = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 59) == 0) en = ~en;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         wr_valid = ($urandom_range(0, 9) == 0);
         mask     = 16'(16'hFFFF >> (4 * $urandom_range(0, 3)));
         wr_data  = 16'($urandom) & mask;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
